tz_rom_arbiter: RTL and testbench

Read-port arbiter and sequencer for the single-port 32x16 timezone-string ROM. The ROM is shared by two requesters: the LCD action path and the UART handler. The arbiter grants one requester at a time in round-robin order and drives the ROM enable, output-register enable and address. It returns the 32-bit word to the winning requester with a registered one-cycle acknowledge. It replaces the tied-high output-register enable and the direct requester-to-ROM enable connection.

---
 rtl/tz_rom_arbiter_if.sv | 32 +++
 rtl/tz_rom_arbiter.sv | 119 +++++++++++
 tb/tb_tz_rom_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tz_rom_arbiter_if.sv
// Bundle of the two requester ports and the ROM read port around tz_rom_arbiter.
// "slave" is the arbiter's view; "master" is the requesters plus the ROM.
interface tz_rom_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
);
    logic              LCD_REQ;
    logic [ADDR_W-1:0] LCD_ADDR;
    logic              LCD_ACK;
    logic [DATA_W-1:0] LCD_RDATA;
    logic              UART_REQ;
    logic [ADDR_W-1:0] UART_ADDR;
    logic              UART_ACK;
    logic [DATA_W-1:0] UART_RDATA;
    logic              ROM_EN;
    logic              ROM_REGCE;
    logic [ADDR_W-1:0] ROM_ADDR;
    logic [DATA_W-1:0] ROM_DOUT;
    logic              BUSY;

    modport slave (
        input  LCD_REQ, LCD_ADDR, UART_REQ, UART_ADDR, ROM_DOUT,
        output LCD_ACK, LCD_RDATA, UART_ACK, UART_RDATA,
        output ROM_EN, ROM_REGCE, ROM_ADDR, BUSY
    );

    modport master (
        output LCD_REQ, LCD_ADDR, UART_REQ, UART_ADDR, ROM_DOUT,
        input  LCD_ACK, LCD_RDATA, UART_ACK, UART_RDATA,
        input  ROM_EN, ROM_REGCE, ROM_ADDR, BUSY
    );
endinterface

// File: rtl/tz_rom_arbiter.sv
// Round-robin read arbiter/sequencer for the shared single-port timezone ROM.
// One read at a time: IDLE -> ISSUE (ena) -> [WAIT (regcea)] -> CAPTURE -> IDLE,
// with a registered one-cycle ACK to the owner alongside its updated RDATA.
module tz_rom_arbiter #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              CLK,
    input  logic              RESETN,
    tz_rom_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

    localparam logic OwnLcd  = 1'b0;
    localparam logic OwnUart = 1'b1;

    state_e            state_q, state_d;
    // Current owner; it also serves as the round-robin last-grant pointer.
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_en_q, rom_en_d;
    logic              rom_regce_q, rom_regce_d;
    logic              busy_q, busy_d;
    logic              lcd_ack_q, lcd_ack_d;
    logic              uart_ack_q, uart_ack_d;
    logic [DATA_W-1:0] lcd_rdata_q, lcd_rdata_d;
    logic [DATA_W-1:0] uart_rdata_q, uart_rdata_d;
    logic              lcd_elig, uart_elig, grant_uart;

    // Next-state, grant decision, capture and registered output decode.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rom_addr_d   = rom_addr_q;
        lcd_ack_d    = 1'b0;
        uart_ack_d   = 1'b0;
        lcd_rdata_d  = lcd_rdata_q;
        uart_rdata_d = uart_rdata_q;
        grant_uart   = 1'b0;
        // A requester in its ACK cycle is not re-eligible until the next IDLE cycle.
        lcd_elig     = bus.LCD_REQ & ~lcd_ack_q;
        uart_elig    = bus.UART_REQ & ~uart_ack_q;

        unique case (state_q)
            StIdle: begin
                if (lcd_elig || uart_elig) begin
                    if (lcd_elig && uart_elig) begin
                        grant_uart = (owner_q == OwnLcd);
                    end else begin
                        grant_uart = uart_elig;
                    end
                    owner_d    = grant_uart ? OwnUart : OwnLcd;
                    rom_addr_d = grant_uart ? bus.UART_ADDR : bus.LCD_ADDR;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                state_d = (READ_LATENCY == 2) ? StWait : StCapture;
            end
            StWait: begin
                state_d = StCapture;
            end
            StCapture: begin
                if (owner_q == OwnUart) begin
                    uart_rdata_d = bus.ROM_DOUT;
                    uart_ack_d   = 1'b1;
                end else begin
                    lcd_rdata_d = bus.ROM_DOUT;
                    lcd_ack_d   = 1'b1;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rom_en_d    = (state_d == StIssue);
        rom_regce_d = (READ_LATENCY == 2) && (state_d == StWait);
        busy_d      = (state_d != StIdle);
    end

    // State and output registers; reset aborts any read in flight without an ACK.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= StIdle;
            owner_q      <= OwnUart;
            rom_addr_q   <= '0;
            rom_en_q     <= 1'b0;
            rom_regce_q  <= 1'b0;
            busy_q       <= 1'b0;
            lcd_ack_q    <= 1'b0;
            uart_ack_q   <= 1'b0;
            lcd_rdata_q  <= '0;
            uart_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rom_addr_q   <= rom_addr_d;
            rom_en_q     <= rom_en_d;
            rom_regce_q  <= rom_regce_d;
            busy_q       <= busy_d;
            lcd_ack_q    <= lcd_ack_d;
            uart_ack_q   <= uart_ack_d;
            lcd_rdata_q  <= lcd_rdata_d;
            uart_rdata_q <= uart_rdata_d;
        end
    end

    assign bus.LCD_ACK    = lcd_ack_q;
    assign bus.LCD_RDATA  = lcd_rdata_q;
    assign bus.UART_ACK   = uart_ack_q;
    assign bus.UART_RDATA = uart_rdata_q;
    assign bus.ROM_EN     = rom_en_q;
    assign bus.ROM_REGCE  = rom_regce_q;
    assign bus.ROM_ADDR   = rom_addr_q;
    assign bus.BUSY       = busy_q;
endmodule

// File: tb/tb_tz_rom_arbiter.sv
// Bench for tz_rom_arbiter: a READ_LATENCY=2 instance driven from a per-cycle vector
// table and hand sequences, plus a READ_LATENCY=1 instance for the short pipeline.
module tb_tz_rom_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tz_rom_arbiter_if #(.ADDR_W(4), .DATA_W(32)) bus0 ();
    tz_rom_arbiter_if #(.ADDR_W(4), .DATA_W(32)) bus1 ();

    tz_rom_arbiter #(.READ_LATENCY(2), .ADDR_W(4), .DATA_W(32)) u_dut0 (
        .CLK(clk), .RESETN(rst_n), .bus(bus0)
    );
    tz_rom_arbiter #(.READ_LATENCY(1), .ADDR_W(4), .DATA_W(32)) u_dut1 (
        .CLK(clk), .RESETN(rst_n), .bus(bus1)
    );

    function automatic logic [31:0] romw(input logic [3:0] a);
        return 32'h5554_432D + {28'd0, a};
    endfunction

    // ROM models: core register on ena, output register on regcea.
    logic [31:0] core0, oreg0, core1;
    always @(posedge clk) begin
        if (bus0.ROM_EN) core0 <= romw(bus0.ROM_ADDR);
        if (bus0.ROM_REGCE) oreg0 <= core0;
        if (bus1.ROM_EN) core1 <= romw(bus1.ROM_ADDR);
    end
    assign bus0.ROM_DOUT = oreg0;
    assign bus1.ROM_DOUT = core1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit sb_on = 1'b0;
    logic [31:0] lcd_exp[$];
    logic [31:0] uart_exp[$];
    logic [31:0] sb_e;

    typedef struct {
        logic        lreq;
        logic [3:0]  laddr;
        logic        ureq;
        logic [3:0]  uaddr;
        logic [4:0]  ctl;   // {ROM_EN, ROM_REGCE, BUSY, LCD_ACK, UART_ACK}
        logic [3:0]  addr;
        logic [31:0] lrd;
        logic [31:0] urd;
    } vec_t;
    vec_t tbl[17];

    function automatic vec_t mk(input logic lr, input logic [3:0] la, input logic ur,
                                input logic [3:0] ua, input logic [4:0] ctl,
                                input logic [3:0] addr, input logic [31:0] lrd,
                                input logic [31:0] urd);
        vec_t v;
        v.lreq = lr; v.laddr = la; v.ureq = ur; v.uaddr = ua;
        v.ctl = ctl; v.addr = addr; v.lrd = lrd; v.urd = urd;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_ack(input bit uart, input int limit, output int seen);
        seen = -1;
        for (int k = 0; k < limit; k++) begin
            if ((uart ? bus0.UART_ACK : bus0.LCD_ACK) === 1'b1) begin
                seen = cyc;
                break;
            end
            step();
        end
    endtask

    // Scoreboard: every ACK on the latency-2 instance must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n && sb_on) begin
            if (bus0.LCD_ACK) begin
                checks++;
                if (lcd_exp.size() == 0) begin
                    errors++;
                    $display("FAIL lcd_sb: unexpected LCD_ACK, rdata %0h", bus0.LCD_RDATA);
                end else begin
                    sb_e = lcd_exp.pop_front();
                    if (bus0.LCD_RDATA !== sb_e) begin
                        errors++;
                        $display("FAIL lcd_sb: got %0h expected %0h", bus0.LCD_RDATA, sb_e);
                    end
                end
            end
            if (bus0.UART_ACK) begin
                checks++;
                if (uart_exp.size() == 0) begin
                    errors++;
                    $display("FAIL uart_sb: unexpected UART_ACK, rdata %0h", bus0.UART_RDATA);
                end else begin
                    sb_e = uart_exp.pop_front();
                    if (bus0.UART_RDATA !== sb_e) begin
                        errors++;
                        $display("FAIL uart_sb: got %0h expected %0h", bus0.UART_RDATA, sb_e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, seen, last_l, last_u, n_ack, busy_cnt;
        logic prev_l, prev_u;
        logic [31:0] w0, w1, w2, w3;

        w0 = 32'h0;
        w1 = romw(4'd1);
        w2 = romw(4'd2);
        w3 = romw(4'd3);
        // Both requesters tie, LCD wins first, UART follows; then a lone LCD read of entry 3.
        tbl[0]  = mk(1, 1, 1, 2, 5'b00000, 0, w0, w0);
        tbl[1]  = mk(1, 1, 1, 2, 5'b10100, 1, w0, w0);
        tbl[2]  = mk(1, 1, 1, 2, 5'b01100, 1, w0, w0);
        tbl[3]  = mk(1, 1, 1, 2, 5'b00100, 1, w0, w0);
        tbl[4]  = mk(0, 1, 1, 2, 5'b00010, 1, w1, w0);
        tbl[5]  = mk(0, 1, 1, 2, 5'b10100, 2, w1, w0);
        tbl[6]  = mk(0, 1, 1, 2, 5'b01100, 2, w1, w0);
        tbl[7]  = mk(0, 1, 1, 2, 5'b00100, 2, w1, w0);
        tbl[8]  = mk(0, 1, 0, 2, 5'b00001, 2, w1, w2);
        tbl[9]  = mk(0, 1, 0, 2, 5'b00000, 2, w1, w2);
        tbl[10] = mk(1, 3, 0, 2, 5'b00000, 2, w1, w2);
        tbl[11] = mk(1, 3, 0, 2, 5'b10100, 3, w1, w2);
        tbl[12] = mk(1, 3, 0, 2, 5'b01100, 3, w1, w2);
        tbl[13] = mk(1, 3, 0, 2, 5'b00100, 3, w1, w2);
        tbl[14] = mk(0, 3, 0, 2, 5'b00010, 3, w3, w2);
        tbl[15] = mk(0, 3, 0, 2, 5'b00000, 3, w3, w2);
        tbl[16] = mk(0, 3, 0, 2, 5'b00000, 3, w3, w2);

        rst_n = 1'b0;
        bus0.LCD_REQ = 0; bus0.LCD_ADDR = 0; bus0.UART_REQ = 0; bus0.UART_ADDR = 0;
        bus1.LCD_REQ = 0; bus1.LCD_ADDR = 0; bus1.UART_REQ = 0; bus1.UART_ADDR = 0;
        repeat (2) step();

        check("reset_ctl0", {bus0.ROM_EN, bus0.ROM_REGCE, bus0.BUSY, bus0.LCD_ACK,
                             bus0.UART_ACK, bus0.ROM_ADDR}, 0);
        check("reset_rdata0", {bus0.LCD_RDATA, bus0.UART_RDATA}, 0);
        check("reset_ctl1", {bus1.ROM_EN, bus1.ROM_REGCE, bus1.BUSY, bus1.LCD_ACK,
                             bus1.UART_ACK, bus1.ROM_ADDR}, 0);
        rst_n = 1'b1;

        // Table-driven cycle-by-cycle section.
        sb_on = 1'b1;
        prev_l = 1'b0;
        prev_u = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step();
            bus0.LCD_REQ = tbl[i].lreq; bus0.LCD_ADDR = tbl[i].laddr;
            bus0.UART_REQ = tbl[i].ureq; bus0.UART_ADDR = tbl[i].uaddr;
            if (tbl[i].lreq && !prev_l) lcd_exp.push_back(romw(tbl[i].laddr));
            if (tbl[i].ureq && !prev_u) uart_exp.push_back(romw(tbl[i].uaddr));
            prev_l = tbl[i].lreq;
            prev_u = tbl[i].ureq;
            check($sformatf("vec%0d_ctl_addr", i),
                  {bus0.ROM_EN, bus0.ROM_REGCE, bus0.BUSY, bus0.LCD_ACK, bus0.UART_ACK,
                   bus0.ROM_ADDR}, {tbl[i].ctl, tbl[i].addr});
            check($sformatf("vec%0d_rdata", i), {bus0.LCD_RDATA, bus0.UART_RDATA},
                  {tbl[i].lrd, tbl[i].urd});
        end
        check("vec_sb_drained", lcd_exp.size() + uart_exp.size(), 0);

        // Continuous contention: last grant was LCD, so UART leads and they alternate.
        sb_on = 1'b0;
        last_l = 0; last_u = 0; n_ack = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (i == 0) begin
                bus0.LCD_REQ = 1; bus0.LCD_ADDR = 10; bus0.UART_REQ = 1; bus0.UART_ADDR = 11;
            end
            if (i == 40) begin
                bus0.LCD_REQ = 0; bus0.UART_REQ = 0;
            end
            if (bus0.LCD_ACK) begin
                check("cont_order_lcd", n_ack % 2, 1);
                check("cont_gap_lcd", (i - last_l) <= 8, 1);
                check("cont_rdata_lcd", bus0.LCD_RDATA, romw(4'd10));
                last_l = i;
                n_ack++;
            end
            if (bus0.UART_ACK) begin
                check("cont_order_uart", n_ack % 2, 0);
                check("cont_gap_uart", (i - last_u) <= 8, 1);
                check("cont_rdata_uart", bus0.UART_RDATA, romw(4'd11));
                last_u = i;
                n_ack++;
            end
        end
        check("cont_ack_count", n_ack, 10);
        check("cont_idle_after", bus0.BUSY, 0);

        // Address change and REQ drop after grant.
        sb_on = 1'b1;
        step();
        bus0.UART_REQ = 1; bus0.UART_ADDR = 5;
        uart_exp.push_back(romw(4'd5));
        c0 = cyc;
        step();
        step();
        bus0.UART_REQ = 0; bus0.UART_ADDR = 9;
        wait_ack(1'b1, 10, seen);
        check("addrchg_ack_cycle", seen - c0, 4);
        check("addrchg_rom_addr", bus0.ROM_ADDR, 5);
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus0.BUSY) busy_cnt++;
        end
        check("addrchg_no_second_txn", busy_cnt, 0);

        // Asynchronous reset while in WAIT.
        step();
        bus0.LCD_REQ = 1; bus0.LCD_ADDR = 7;
        step();
        step();
        check("rst_mid_in_wait", {bus0.ROM_REGCE, bus0.BUSY}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", {bus0.ROM_EN, bus0.ROM_REGCE, bus0.BUSY, bus0.LCD_ACK,
                              bus0.UART_ACK}, 0);
        check("rst_mid_rdata", {bus0.LCD_RDATA, bus0.UART_RDATA}, 0);
        bus0.LCD_REQ = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
        bus0.LCD_REQ = 1; bus0.LCD_ADDR = 4;
        lcd_exp.push_back(romw(4'd4));
        c0 = cyc;
        wait_ack(1'b0, 10, seen);
        bus0.LCD_REQ = 0;
        check("rst_after_ack_cycle", seen - c0, 4);

        // READ_LATENCY=1 instance: no REGCE, ACK one cycle earlier.
        step();
        bus1.LCD_REQ = 1; bus1.LCD_ADDR = 6;
        c0 = cyc;
        seen = -1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step();
            check("l1_regce_zero", bus1.ROM_REGCE, 0);
            if (bus1.LCD_ACK && seen < 0) begin
                seen = cyc - c0;
                bus1.LCD_REQ = 0;
            end
        end
        check("l1_ack_cycle", seen, 3);
        check("l1_rdata", bus1.LCD_RDATA, romw(4'd6));

        step();
        check("final_sb_drained", lcd_exp.size() + uart_exp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
